// File: rtl/crc_frame_appender.sv
// rtl/crc_frame_appender.sv - byte stream feeder for the CRC-8 engine that appends the frame CRC
module crc_frame_appender #(
   parameter int                   DATA_WIDTH = 8,
   parameter int                   CRC_WIDTH  = 8,
   parameter logic [CRC_WIDTH-1:0] CRC_SEED   = '0,
   parameter int                   TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  crc_en,
   output logic [CRC_WIDTH-1:0]  crc_initial,
   output logic [DATA_WIDTH-1:0] data_in_parallel,
   input  logic [CRC_WIDTH-1:0]  data_out,
   input  logic                  dout_vld,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  timeout_err,
   output logic [15:0]           frame_cnt
);

   localparam int                 CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_KICK,
      S_WAIT,
      S_SEND,
      S_APPEND,
      S_DRAIN
   } state_t;

   state_t                  state_q;
   logic                    in_ready_q;
   logic                    crc_en_q;
   logic [CRC_WIDTH-1:0]    crc_initial_q;
   logic [DATA_WIDTH-1:0]   data_in_q;
   logic                    out_valid_q;
   logic [DATA_WIDTH-1:0]   out_data_q;
   logic                    out_last_q;
   logic                    timeout_err_q;
   logic [15:0]             frame_cnt_q;
   logic [15:0]             frame_cnt_d;
   logic [CNT_W-1:0]        wait_cnt_q;
   logic [CNT_W-1:0]        wait_cnt_d;
   logic [CRC_WIDTH-1:0]    crc_q;
   logic [DATA_WIDTH-1:0]   byte_q;
   logic                    last_q;
   logic [DATA_WIDTH-1:0]   crc_word;

   // Next-state helpers: counter increments and the CRC zero-extended to a stream word
   always_comb begin
      wait_cnt_d                  = wait_cnt_q + CNT_W'(1);
      frame_cnt_d                 = frame_cnt_q + 16'd1;
      crc_word                    = '0;
      crc_word[CRC_WIDTH-1:0]     = crc_q;
   end

   // Frame FSM: one byte in flight, engine handshake, forward byte, append CRC on the last byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         in_ready_q    <= 1'b0;
         crc_en_q      <= 1'b0;
         crc_initial_q <= CRC_SEED;
         data_in_q     <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_last_q    <= 1'b0;
         timeout_err_q <= 1'b0;
         frame_cnt_q   <= '0;
         wait_cnt_q    <= '0;
         crc_q         <= CRC_SEED;
         byte_q        <= '0;
         last_q        <= 1'b0;
      end else begin
         crc_en_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               in_ready_q <= 1'b1;
               if (in_valid && in_ready_q) begin
                  byte_q        <= in_data;
                  last_q        <= in_last;
                  in_ready_q    <= 1'b0;
                  // Engine operands are loaded here and held until the result returns
                  crc_en_q      <= 1'b1;
                  data_in_q     <= in_data;
                  crc_initial_q <= crc_q;
                  state_q       <= S_KICK;
               end
            end
            S_KICK: begin
               // A result strobe coincident with crc_en cannot belong to this byte
               wait_cnt_q <= '0;
               state_q    <= S_WAIT;
            end
            S_WAIT: begin
               if (dout_vld) begin
                  crc_q       <= data_out;
                  out_valid_q <= 1'b1;
                  out_data_q  <= byte_q;
                  out_last_q  <= 1'b0;
                  state_q     <= S_SEND;
               end else if (wait_cnt_q == TMO_LAST) begin
                  // Engine is stuck: abandon the frame, downstream sees it truncated
                  timeout_err_q <= 1'b1;
                  crc_q         <= CRC_SEED;
                  in_ready_q    <= 1'b1;
                  state_q       <= last_q ? S_IDLE : S_DRAIN;
               end else begin
                  wait_cnt_q <= wait_cnt_d;
               end
            end
            S_SEND: begin
               if (out_ready) begin
                  if (last_q) begin
                     out_data_q <= crc_word;
                     out_last_q <= 1'b1;
                     state_q    <= S_APPEND;
                  end else begin
                     out_valid_q <= 1'b0;
                     in_ready_q  <= 1'b1;
                     state_q     <= S_IDLE;
                  end
               end
            end
            S_APPEND: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  crc_q       <= CRC_SEED;
                  frame_cnt_q <= frame_cnt_d;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            S_DRAIN: begin
               // Swallow the rest of the abandoned frame up to its last byte
               in_ready_q <= 1'b1;
               if (in_valid && in_ready_q && in_last) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready         = in_ready_q;
   assign crc_en           = crc_en_q;
   assign crc_initial      = crc_initial_q;
   assign data_in_parallel = data_in_q;
   assign out_valid        = out_valid_q;
   assign out_data         = out_data_q;
   assign out_last         = out_last_q;
   assign timeout_err      = timeout_err_q;
   assign frame_cnt        = frame_cnt_q;

endmodule
